// File: rtl/imem_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : imem_refill_unit
// Brief    : Instruction-cache line refill engine with pipelined, bounded
//            outstanding RAM reads, abort-and-drain, and miss re-arm.
// Revision : 1.0 - initial release
// ============================================================================
module imem_refill_unit #(
    parameter int PC_SIZE   = 32,
    parameter int WORD_W    = 32,
    parameter int BLOCK_W   = 512,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cache_miss,
    input  logic [PC_SIZE-1:0] ram_address,
    output logic               mem_req,
    output logic [PC_SIZE-1:0] mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic [WORD_W-1:0]  mem_word,
    output logic               word_ready,
    output logic               refill_busy
);

    localparam int NWORDS     = BLOCK_W / WORD_W;
    localparam int CNT_W      = $clog2(NWORDS) + 1;
    localparam int BYTE_SHIFT = $clog2(WORD_W / 8);

    localparam logic [CNT_W-1:0] c_nwords    = CNT_W'(NWORDS);
    localparam logic [CNT_W-1:0] c_max_outst = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_HIT = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [PC_SIZE-1:0] r_base, w_base_next;
    logic [CNT_W-1:0]   r_issue_cnt, w_issue_next;
    logic [CNT_W-1:0]   r_ret_cnt, w_ret_next;
    logic [CNT_W-1:0]   r_outst, w_outst_next;
    logic               r_mem_req, w_req_next;
    logic [PC_SIZE-1:0] r_mem_addr, w_addr_next;
    logic [WORD_W-1:0]  r_mem_word, w_word_next;
    logic               r_word_ready, w_ready_next;
    logic               r_refill_busy, w_busy_next;
    logic               w_grant;
    logic               w_miss_same;

    // Requests are registered, so a high r_mem_req is the one the RAM sees.
    assign w_grant     = r_mem_req & mem_gnt;
    assign w_miss_same = cache_miss && (ram_address == r_base);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_issue_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_outst       <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_word    <= '0;
            r_word_ready  <= 1'b0;
            r_refill_busy <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_base        <= w_base_next;
            r_issue_cnt   <= w_issue_next;
            r_ret_cnt     <= w_ret_next;
            r_outst       <= w_outst_next;
            r_mem_req     <= w_req_next;
            r_mem_addr    <= w_addr_next;
            r_mem_word    <= w_word_next;
            r_word_ready  <= w_ready_next;
            r_refill_busy <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_issue_next = r_issue_cnt;
        w_ret_next   = r_ret_cnt;
        w_outst_next = r_outst;
        w_req_next   = 1'b0;
        w_addr_next  = r_mem_addr;
        w_word_next  = r_mem_word;
        w_ready_next = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cache_miss) begin
                    w_base_next  = ram_address;
                    w_issue_next = '0;
                    w_ret_next   = '0;
                    w_outst_next = '0;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_grant) w_issue_next = r_issue_cnt + c_one;
                if (mem_rvalid) w_ret_next = r_ret_cnt + c_one;
                if (w_grant && !mem_rvalid) w_outst_next = r_outst + c_one;
                else if (!w_grant && mem_rvalid) w_outst_next = r_outst - c_one;

                // A grant in the abort cycle is still counted so DRAIN waits for it.
                if (!w_miss_same) begin
                    w_state_next = S_DRAIN;
                end else begin
                    if (mem_rvalid) begin
                        w_word_next  = mem_rdata;
                        w_ready_next = 1'b1;
                    end
                    if (w_ret_next == c_nwords) begin
                        w_state_next = S_WAIT_HIT;
                    end else begin
                        w_req_next  = (w_issue_next < c_nwords) && (w_outst_next < c_max_outst);
                        w_addr_next = r_base + (PC_SIZE'(w_issue_next) << BYTE_SHIFT);
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rvalid && (r_outst != '0)) w_outst_next = r_outst - c_one;
                if (w_outst_next == '0) w_state_next = S_IDLE;
            end
            S_WAIT_HIT: begin
                if (!w_miss_same) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_word    = r_mem_word;
    assign word_ready  = r_word_ready;
    assign refill_busy = r_refill_busy;

`ifndef SYNTHESIS
    a_no_rvalid_when_quiet: assert property (@(posedge clk) disable iff (!nrst)
        !(mem_rvalid && ((r_state == S_IDLE) || (r_state == S_WAIT_HIT))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_refill_unit
// Brief    : Directed self-checking bench with an in-order RAM model and a
//            block-level scoreboard of expected addresses and words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_refill_unit;

    localparam int PC_SIZE   = 32;
    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int MAX_OUTST = 4;
    localparam int NWORDS    = 16;

    logic                clk = 1'b0;
    logic                nrst;
    logic                cache_miss;
    logic [PC_SIZE-1:0]  ram_address;
    logic                mem_req;
    logic [PC_SIZE-1:0]  mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [WORD_W-1:0]   mem_rdata;
    logic [WORD_W-1:0]   mem_word;
    logic                word_ready;
    logic                refill_busy;

    always #5 clk = ~clk;

    imem_refill_unit #(
        .PC_SIZE   (PC_SIZE),
        .WORD_W    (WORD_W),
        .BLOCK_W   (BLOCK_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cache_miss  (cache_miss),
        .ram_address (ram_address),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_word    (mem_word),
        .word_ready  (word_ready),
        .refill_busy (refill_busy)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } resp_t;

    resp_t       pending[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    logic [31:0] ref_base = '0;
    int          words_seen = 0;
    int          n_granted = 0;
    int          max_inflight = 0;
    int          last_word_cyc = 0;
    int          cnt_stall_addr = 0;
    bit          aborted = 1'b0;
    int          c0;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: score the outputs of the last edge, then drive the RAM side.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (nrst) begin
            if (word_ready) begin
                check("word_data", mem_word, data_fn(ref_base + 32'(4 * words_seen)));
                check("word_after_abort", aborted, 0);
                check("word_count_le16", words_seen < NWORDS, 1);
                words_seen++;
                last_word_cyc = cyc;
            end
            if (pending.size() > max_inflight) max_inflight = pending.size();
            check("inflight_le_max", pending.size() <= MAX_OUTST, 1);
            if (mem_req) begin
                check("req_addr", mem_addr, ref_base + 32'(4 * n_granted));
                check("req_after_abort", aborted, 0);
                check("req_below_limit", pending.size() < MAX_OUTST, 1);
                if (mem_addr == stall_addr) cnt_stall_addr++;
            end
        end
        if (!nrst) begin
            pending.delete();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            if (stall_left > 0 && mem_req && mem_addr == stall_addr) begin
                mem_gnt = 1'b0;
                stall_left--;
            end else begin
                mem_gnt = 1'b1;
            end
            if (mem_req && mem_gnt) begin
                pending.push_back('{due: cyc + lat, addr: mem_addr});
                n_granted++;
            end
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_fn(pending[0].addr);
                void'(pending.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
            end
        end
    endtask

    task automatic start_miss(input logic [31:0] a);
        cache_miss  = 1'b1;
        ram_address = a;
        ref_base    = a;
        words_seen  = 0;
        n_granted   = 0;
        aborted     = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words_seen < target && n < budget) begin
            tick();
            n++;
        end
        check("words_reached", words_seen, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (refill_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", refill_busy, 0);
    endtask

    initial begin
        nrst        = 1'b0;
        cache_miss  = 1'b0;
        ram_address = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        repeat (2) tick();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_word", mem_word, 0);
        check("rst_ready", word_ready, 0);
        check("rst_busy", refill_busy, 0);
        nrst = 1'b1;
        tick();
        check("post_rst_busy", refill_busy, 0);

        // Zero-wait RAM, miss at 0x100
        lat = 1;
        start_miss(32'h0000_0100);
        c0 = cyc;
        wait_words(16, 100);
        check("t1_last_word_latency", last_word_cyc - (c0 + 1), 18);
        cache_miss = 1'b0;
        wait_idle(20);

        // Long RAM latency saturates the outstanding limit
        lat = 6;
        max_inflight = 0;
        start_miss(32'h0000_4A40);
        wait_words(16, 300);
        check("t2_max_inflight", max_inflight, 4);
        cache_miss = 1'b0;
        wait_idle(20);

        // Grant stalled for three cycles on word 5
        lat = 1;
        stall_addr = 32'h0000_0114;
        stall_left = 3;
        cnt_stall_addr = 0;
        start_miss(32'h0000_0100);
        wait_words(16, 100);
        check("t3_addr114_cycles", cnt_stall_addr, 4);
        check("t3_stall_used", stall_left, 0);
        cache_miss = 1'b0;
        wait_idle(20);

        // Miss withdrawn after 7 words with 3 reads in flight
        lat = 3;
        start_miss(32'h8000_0FC0);
        wait_words(7, 100);
        cache_miss = 1'b0;
        aborted    = 1'b1;
        check("t4_inflight_at_abort", pending.size(), 3);
        wait_idle(50);
        repeat (3) tick();
        check("t4_words_after_drain", words_seen, 7);
        check("t4_granted", n_granted, 11);
        check("t4_drained", pending.size(), 0);
        check("t4_busy_low", refill_busy, 0);

        // Miss held after completion: parked until it clears
        lat = 1;
        start_miss(32'hFFFF_FFC0);
        wait_words(16, 100);
        repeat (2) begin
            tick();
            check("t5_no_req", mem_req, 0);
            check("t5_busy_hold", refill_busy, 1);
        end
        check("t5_word_total", words_seen, 16);
        cache_miss = 1'b0;
        tick();
        check("t5_busy_low", refill_busy, 0);

        // Asynchronous reset in the middle of a refill
        lat = 2;
        start_miss(32'h0000_0200);
        wait_words(5, 100);
        #2 nrst = 1'b0;
        #1;
        check("t6_req", mem_req, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_word", mem_word, 0);
        check("t6_ready", word_ready, 0);
        check("t6_busy", refill_busy, 0);
        cache_miss = 1'b0;
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        check("t6_idle_after_rst", refill_busy, 0);
        start_miss(32'h0000_0200);
        wait_words(16, 100);
        cache_miss = 1'b0;
        wait_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
